// File: rtl/multiexp_pnt_scl_feeder_pkg.sv
// multiexp_pnt_scl_feeder_pkg: shared widths, feeder state and buffer entry types
package multiexp_pnt_scl_feeder_pkg;
  localparam int FE_BITS = 256;
  localparam int PT_BITS = 1536;
  typedef logic [FE_BITS-1:0] fe_t;
  typedef logic [PT_BITS-1:0] fp2_jb_point_t;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} feed_state_t;
  typedef struct packed {
    fp2_jb_point_t pnt;
    fe_t           scl;
  } feed_ent_t;
endpackage

// File: rtl/multiexp_feed_buf.sv
// multiexp_feed_buf: MAX_IN-entry (point, scalar) register array, one write port, one async read port
module multiexp_feed_buf
  import multiexp_pnt_scl_feeder_pkg::*;
#(
  parameter int MAX_IN = 16,
  localparam int AW = $clog2(MAX_IN)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  feed_ent_t     i_wdat,
  input  logic [AW-1:0] i_raddr,
  output feed_ent_t     o_rdat
);
  feed_ent_t mem_q [MAX_IN];
  // contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdat;
  end
  assign o_rdat = mem_q[i_raddr];
endmodule

// File: rtl/multiexp_pnt_scl_feeder.sv
// multiexp_pnt_scl_feeder: buffers a job of (point, scalar) pairs and replays them DAT_BITS rounds with scalar<<round
// Optional tag sideband on o_ctl enabled by MULTIEXP_FEED_TAG_EN.
module multiexp_pnt_scl_feeder
  import multiexp_pnt_scl_feeder_pkg::*;
#(
  parameter int MAX_IN   = 16,
  parameter int DAT_BITS = FE_BITS,
  parameter int PNT_BITS = PT_BITS,
  parameter int CTL_BITS = 9,
  localparam int CW = $clog2(MAX_IN) + 1,
  localparam int AW = $clog2(MAX_IN),
  localparam int JW = $clog2(DAT_BITS),
  localparam int W  = PNT_BITS + DAT_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [CW-1:0]       i_num_in,
  input  logic [W-1:0]        i_ld_dat,
  input  logic                i_ld_val,
  output logic                o_ld_rdy,
  output logic [W-1:0]        o_dat,
  output logic                o_val,
  input  logic                i_rdy,
  output logic                o_sop,
  output logic                o_eop,
  output logic [CTL_BITS-1:0] o_ctl,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);
  feed_state_t state_q, state_d;
  logic [CW-1:0] n_q, n_d, wr_q, wr_d, i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic last_q, last_d, err_q, err_d, done_q, done_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [W-1:0] dat_q, dat_d;
  feed_ent_t rd;
  logic ld, last_pair, last_rnd, num_ok;
  assign last_pair = i_q == n_q - CW'(1);
  assign last_rnd  = j_q == JW'(DAT_BITS - 1);
  assign num_ok    = i_num_in != '0 && i_num_in <= CW'(MAX_IN);
  // last_q marks that the eop beat is already in the output register
  assign ld        = state_q == EMIT && !last_q && (!val_q || i_rdy);
  multiexp_feed_buf #(.MAX_IN(MAX_IN)) u_buf (
    .i_clk  (i_clk),
    .i_we   (state_q == LOAD && i_ld_val),
    .i_waddr(AW'(wr_q)),
    .i_wdat (i_ld_dat),
    .i_raddr(AW'(i_q)),
    .o_rdat (rd)
  );
  // next-state, counters and output beat register loading
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wr_d    = wr_q;
    i_d     = i_q;
    j_d     = j_q;
    last_d  = last_q;
    err_d   = err_q;
    done_d  = 1'b0;
    val_d   = val_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (i_start) begin
        err_d   = !num_ok;
        done_d  = !num_ok;
        n_d     = num_ok ? i_num_in : n_q;
        wr_d    = '0;
        state_d = num_ok ? LOAD : IDLE;
      end
      LOAD: if (i_ld_val) begin
        wr_d = wr_q + CW'(1);
        if (wr_q == n_q - CW'(1)) begin
          state_d = EMIT;
          i_d     = '0;
          j_d     = '0;
          last_d  = 1'b0;
        end
      end
      EMIT: if (val_q && i_rdy) begin
        val_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        state_d = eop_q ? DONE : EMIT;
        done_d  = eop_q;
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      val_d  = 1'b1;
      dat_d  = {rd.pnt, rd.scl << j_q};
      sop_d  = i_q == '0 && j_q == '0;
      eop_d  = last_pair && last_rnd;
      last_d = last_pair && last_rnd;
      i_d    = last_pair ? '0 : i_q + CW'(1);
      j_d    = last_pair ? j_q + JW'(1) : j_q;
    end
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      wr_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wr_q    <= wr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      last_q  <= last_d;
      err_q   <= err_d;
      done_q  <= done_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      dat_q   <= dat_d;
    end
  end
`ifdef MULTIEXP_FEED_TAG_EN
  logic [CTL_BITS-1:0] ctl_q;
  // tag travels with the beat: round number and last-pair-of-round marker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ctl_q <= '0;
    else if (ld) ctl_q <= CTL_BITS'({j_q, last_pair});
  end
  assign o_ctl = ctl_q;
`else
  assign o_ctl = '0;
`endif
  assign o_ld_rdy = state_q == LOAD;
  assign o_busy   = state_q != IDLE;
  assign o_dat    = dat_q;
  assign o_val    = val_q;
  assign o_sop    = sop_q;
  assign o_eop    = eop_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// tb_multiexp_pnt_scl_feeder: scoreboard bench for the point/scalar feeder
module tb_multiexp_pnt_scl_feeder;
  localparam int MAX_IN = 16;
  localparam int DB = 256;
  localparam int PB = 1536;
  localparam int W = PB + DB;
  localparam int CW = 5;

  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_ld_val = 0, i_rdy = 1;
  logic [CW-1:0] i_num_in = '0;
  logic [W-1:0] i_ld_dat = '0;
  logic o_ld_rdy, o_val, o_sop, o_eop, o_busy, o_done, o_err;
  logic [W-1:0] o_dat;
  logic [8:0] o_ctl;

  multiexp_pnt_scl_feeder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_in(i_num_in),
    .i_ld_dat(i_ld_dat), .i_ld_val(i_ld_val), .o_ld_rdy(o_ld_rdy),
    .o_dat(o_dat), .o_val(o_val), .i_rdy(i_rdy), .o_sop(o_sop), .o_eop(o_eop),
    .o_ctl(o_ctl), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;
  int cyc = 0, beats = 0, first_cyc = 0, eop_cyc = 0, job_b0 = 0;
  bit rdy_rand = 0, stall = 0;
  logic [W-1:0] hold_dat;
  logic [2:0] hold_flags;
  logic [W+1:0] q[$];
  logic [PB-1:0] pnt_a[MAX_IN];
  logic [DB-1:0] scl_a[MAX_IN];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    int k = 0;
    checks++;
    if (got !== want) begin
      errors++;
      for (int w = W / 64 - 1; w >= 0; w--) if (got[w*64+:64] !== want[w*64+:64]) k = w;
      $display("FAIL %s: got %h expected %h (64-bit word %0d)", tag, got[k*64+:64], want[k*64+:64], k);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge i_clk);
    #1 i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // scoreboard monitor: pops one expected beat per handshake, checks hold under backpressure
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) stall = 0;
    else begin
      if (stall) begin
        check("hold_dat", o_dat, hold_dat);
        check("hold_flags", {o_val, o_sop, o_eop}, hold_flags);
      end
      if (o_val && i_rdy) begin
        if (q.size() == 0) check("extra_beat", o_val, 0);
        else begin
          logic [W+1:0] want;
          want = q.pop_front();
          check("beat_dat", o_dat, want[W-1:0]);
          check("beat_flags", {o_sop, o_eop}, want[W+1:W]);
        end
        beats++;
        if (o_sop) first_cyc = cyc;
        if (o_eop) eop_cyc = cyc;
      end
      stall = o_val && !i_rdy;
      hold_dat = o_dat;
      hold_flags = {o_val, o_sop, o_eop};
    end
  end

  task automatic fill_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < PB / 32; w++) pnt_a[i][w*32+:32] = $urandom;
      for (int w = 0; w < DB / 32; w++) scl_a[i][w*32+:32] = $urandom;
      scl_a[i][DB-1] = 1'b1;
    end
  endtask

  task automatic start_job(input int n, input bit rnd_ld);
    int k = 0, g = 0;
    bit take;
    @(posedge i_clk);
    #1;
    job_b0 = beats;
    for (int j = 0; j < DB; j++)
      for (int i = 0; i < n; i++) begin
        logic [DB-1:0] s;
        s = scl_a[i] << j;
        q.push_back({1'(j == 0 && i == 0), 1'(j == DB - 1 && i == n - 1), pnt_a[i], s});
      end
    i_num_in = CW'(n);
    i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    check("busy_load", o_busy, 1);
    check("err_clear", o_err, 0);
    while (k < n && g < 1000) begin
      i_ld_val = rnd_ld ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ld_dat = {pnt_a[k], scl_a[k]};
      take = i_ld_val && o_ld_rdy;
      @(posedge i_clk);
      #1;
      if (take) k++;
      g++;
    end
    i_ld_val = 0;
    check("load_count", k, n);
  endtask

  task automatic wait_done(input string tag, input int n);
    int c = 0;
    while (!o_done && c < 20000) begin
      @(negedge i_clk);
      c++;
    end
    check({tag, "_done_seen"}, o_done, 1);
    check({tag, "_done_timing"}, cyc, eop_cyc + 1);
    check({tag, "_beats"}, beats - job_b0, n * DB);
    check({tag, "_q_empty"}, q.size(), 0);
    @(negedge i_clk);
    check({tag, "_done_pulse"}, o_done, 0);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic err_start(input int n);
    int b;
    @(posedge i_clk);
    #1 b = beats;
    i_num_in = CW'(n);
    i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    check("err_set", o_err, 1);
    check("err_done", o_done, 1);
    check("err_busy", o_busy, 0);
    repeat (3) @(posedge i_clk);
    #1;
    check("err_sticky", o_err, 1);
    check("err_done_low", o_done, 0);
    check("err_no_beats", beats - b, 0);
  endtask

  initial begin
    int c;
    #12;
    check("rst_val", o_val, 0);
    check("rst_dat", o_dat, 0);
    check("rst_flags", {o_ld_rdy, o_sop, o_eop, o_busy, o_done, o_err}, 0);
    check("rst_ctl", o_ctl, 0);
    i_rst_n = 1;

    fill_pairs(4);
    start_job(4, 0);
    wait_done("n4", 4);
    check("n4_throughput", eop_cyc - first_cyc, 4 * DB - 1);

    rdy_rand = 1;
    start_job(4, 1);
    wait_done("n4_rand", 4);
    rdy_rand = 0;

    err_start(0);
    err_start(17);

    fill_pairs(1);
    scl_a[0] = 1;
    start_job(1, 0);
    wait_done("n1", 1);

    fill_pairs(4);
    start_job(4, 0);
    c = 0;
    while (beats - job_b0 < 100 && c < 5000) begin
      @(negedge i_clk);
      c++;
    end
    check("abort_at_100", beats - job_b0, 100);
    #2 i_rst_n = 0;
    #1;
    check("abort_val", o_val, 0);
    check("abort_dat", o_dat, 0);
    check("abort_flags", {o_ld_rdy, o_sop, o_eop, o_busy, o_done, o_err}, 0);
    q.delete();
    repeat (3) @(negedge i_clk);
    check("abort_no_done", o_done, 0);
    i_rst_n = 1;
    fill_pairs(2);
    start_job(2, 0);
    wait_done("after_abort", 2);

    fill_pairs(2);
    start_job(2, 0);
    repeat (20) @(negedge i_clk);
    @(posedge i_clk);
    #1 i_num_in = 3;
    i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
    wait_done("start_in_emit", 2);
    check("start_in_emit_err", o_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiexp_pnt_scl_feeder.md
Name: multiexp_pnt_scl_feeder

Overview:
- Source end of the multiexp G2 core's point/scalar input stream.
- Buffers up to MAX_IN (point, scalar) pairs loaded from an upstream stream.
- Replays the buffer DAT_BITS times as rounds j = 0..DAT_BITS-1; each round emits every pair in index order with the scalar shifted left by j.
- Output beat format {point, scalar<<j}, one beat per cycle under backpressure. This is the order the core consumes to take the scalar MSB each round.

Parameters:
- MAX_IN, 16, buffer depth (maximum pairs per job).
- DAT_BITS, 256, scalar / field-element width ($bits(fe_t)).
- PNT_BITS, 1536, fp2 Jacobian point width ($bits(fp2_jb_point_t)).
- CTL_BITS, 9, sideband control width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse: begin a job with i_num_in pairs.
- i_num_in  in  $clog2(MAX_IN)+1  pair count, sampled on i_start.
- i_ld_dat  in  PNT_BITS+DAT_BITS  load beat {point, scalar}.
- i_ld_val  in  1  load beat valid.
- o_ld_rdy  out  1  load ready.
- o_dat  out  PNT_BITS+DAT_BITS  output beat {point, scalar<<j}.
- o_val  out  1  output valid.
- i_rdy  in  1  output ready.
- o_sop  out  1  first beat of job.
- o_eop  out  1  last beat of job.
- o_ctl  out  CTL_BITS  sideband (see Optional Feature).
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle pulse at job end.
- o_err  out  1  sticky bad-count flag, cleared by the next accepted i_start.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all counters 0. o_ld_rdy, o_val, o_sop, o_eop, o_busy, o_done, o_err = 0; o_dat = 0; o_ctl = 0. Buffer contents are don't-care.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - i_start with 1 <= i_num_in <= MAX_IN: latch n, clear o_err, go to LOAD.
  - i_num_in = 0 or > MAX_IN: set o_err, pulse o_done next cycle, stay IDLE, emit no beats.
- LOAD:
  - o_ld_rdy = 1. Each beat with i_ld_val & o_ld_rdy writes buf[wr_idx] and increments wr_idx.
  - After the n-th accepted beat, o_ld_rdy drops the next cycle and the state goes to EMIT.
- EMIT (round counter j, index counter i):
  - Output register loads a new beat when !o_val | i_rdy: o_dat = {buf[i].pnt, buf[i].scl << j}.
  - Shift is truncated to DAT_BITS; bits shifted past the MSB are discarded.
  - i wraps n-1 -> 0 and then increments j.
  - o_sop = 1 on beat (j=0, i=0); o_eop = 1 on beat (j=DAT_BITS-1, i=n-1).
  - First o_val asserts 1 cycle after entering EMIT. With i_rdy held high, throughput is 1 beat/cycle, giving exactly n*DAT_BITS beats.
- AXI rules: o_dat, o_val, o_sop, o_eop and o_ctl hold stable while o_val & !i_rdy. o_val never drops without a handshake.
- DONE: entered when the eop beat handshakes; o_done pulses for 1 cycle; next state IDLE.
- o_busy = 1 in LOAD, EMIT and DONE.
- i_start outside IDLE is ignored.
- Async reset mid-LOAD or mid-EMIT aborts immediately. Beats in flight are lost, and no o_done is generated.
- n = 1: every beat is pair 0; o_sop and o_eop fall on different beats (DAT_BITS beats total).

Optional Feature:
- Macro: MULTIEXP_FEED_TAG_EN.
- Defined: o_ctl = {j[7:0], i == n-1}. j occupies o_ctl[8:1]; o_ctl[0] marks the last pair of the round.
- Undefined: o_ctl is tied to 0 and the tag logic is removed.

Decomposition:
- bn128_pkg (already holds these): fe_t, fp2_jb_point_t, DAT_BITS/PNT_BITS widths.
- common_pkg: new typedef feed_state_t (IDLE/LOAD/EMIT/DONE) and packed struct feed_ent_t {fp2_jb_point_t pnt; fe_t scl}.
- One natural sub-module: multiexp_feed_buf. Register-array buffer, MAX_IN x feed_ent_t, with one write port and one combinational read port.

Test Plan:
- Load n=4 known pairs, i_rdy=1 -> 1024 beats; beat k = pair k%4 with scalar << (k/4); o_sop on beat 0, o_eop on beat 1023, o_done 1 cycle after. Feeding the stream to multiexp_fp2_core matches the fp2_multiexp_batch model.
- Random i_rdy (50%) and random i_ld_val -> identical beat sequence; o_dat stable whenever o_val & !i_rdy.
- n=1, scalar=1 -> beat j carries scalar 2^j; beat 255 scalar = 1<<255; no overflow bits.
- i_num_in=0, then i_num_in=17 -> o_err=1, o_done pulse, zero beats; next valid i_start clears o_err.
- Deassert i_rst_n at beat 100 of an n=4 job -> all outputs 0 immediately; new n=2 job then runs cleanly with 512 beats.
- i_start pulsed during EMIT -> ignored; beat count and o_done timing unchanged.
